// File: rtl/core_pkg.sv
// core_pkg: shared types for the core front end (fetch queue entry, fetch FSM
// state encoding, default fetch-queue depth).
// Ports: none (package).
package core_pkg;

  localparam int CORE_XLEN   = 32;
  localparam int FETCH_DEPTH = 4;

  typedef enum logic [1:0] {
    FS_BOOT   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2,
    FS_FAULT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] instr;
    logic [CORE_XLEN-1:0] pc_plus4;
    logic                 fault;
  } fetch_entry_t;

  // Sequential successor; wraps modulo 2^CORE_XLEN.
  function automatic logic [CORE_XLEN-1:0] seq_pc(input logic [CORE_XLEN-1:0] pc);
    return pc + CORE_XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: registered sync FIFO of fetch_entry_t with push/pop/flush.
// Ports: push/push_data in, pop in (ignored when empty), flush in (clears the
//   queue; a push in the same cycle lands as the sole entry), valid/head/count out.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         valid,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign valid  = (count != '0);
  // No fall-through: head always comes straight from storage.
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Flush wins over pop; a simultaneous push becomes the only entry.
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
      if (push) mem[0] <= push_data;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage; owns the PC, issues credit-limited reads
//   to a 1-cycle-latency imem and queues {pc, instr, pc+4} entries for ID.
// Ports: halt_i/redirect_i/redirect_pc_i control, imem_* request/response,
//   out_* valid/ready head of the fetch queue.
// Optional: FETCH_MISALIGN_CHECK_EN turns misaligned redirects into fault entries.
module fetch_unit
  import core_pkg::*;
#(
  parameter int               XLEN            = 32,
  parameter int               IMEM_ADDR_WIDTH = 10,
  parameter int               DEPTH           = FETCH_DEPTH,
  parameter logic [XLEN-1:0]  RESET_PC        = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       imem_rd_en_o,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [XLEN-1:0]            imem_rdata_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [XLEN-1:0]            out_instr_o,
  output logic [XLEN-1:0]            out_pc_plus4_o,
  output logic                       out_fault_o
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] issued_pc;
  logic [XLEN-1:0] target;
  logic            inflight;
  logic            drop;
  logic [CW-1:0]   count;
  logic            credit;
  logic            issue;
  logic            bad_target;
  logic            push;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target     = redirect_pc_i;
  assign bad_target = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc_i[1:0];
  assign target     = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign bad_target = 1'b0;
`endif

  // The in-flight read already owns a slot, so it counts against the queue.
  assign credit = (count + CW'(inflight)) < CW'(DEPTH);
  // A request issued alongside a good redirect is still sent and then dropped;
  // a faulting redirect sends nothing at all.
  assign issue  = (state == FS_RUN) && !halt_i && credit && !bad_target;

  assign imem_rd_en_o = issue;
  assign imem_addr_o  = pc[IMEM_ADDR_WIDTH+1:2];

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (bad_target) begin
      push      = 1'b1;
      push_data = '{pc: target, instr: '0, pc_plus4: seq_pc(target), fault: 1'b1};
    end else if (inflight && !drop && !redirect_i) begin
      push      = 1'b1;
      push_data = '{pc: issued_pc, instr: imem_rdata_i,
                    pc_plus4: seq_pc(issued_pc), fault: 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FS_BOOT:   state_nxt = FS_RUN;
      FS_RUN:    if (halt_i) state_nxt = FS_HALTED;
      FS_HALTED: if (!halt_i) state_nxt = FS_RUN;
      FS_FAULT:  if (redirect_i) state_nxt = FS_RUN;
      default:   state_nxt = FS_BOOT;
    endcase
    if (bad_target) state_nxt = FS_FAULT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FS_BOOT;
      pc        <= RESET_PC;
      issued_pc <= '0;
      inflight  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      drop     <= issue && redirect_i;
      if (issue) issued_pc <= pc;
      if (redirect_i)  pc <= target;
      else if (issue)  pc <= seq_pc(pc);
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready_i),
    .flush     (redirect_i),
    .valid     (out_valid_o),
    .head      (head),
    .count     (count)
  );

  assign out_pc_o       = head.pc;
  assign out_instr_o    = head.instr;
  assign out_pc_plus4_o = head.pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign out_fault_o    = head.fault;
`else
  logic unused_head_fault;
  assign unused_head_fault = head.fault;
  assign out_fault_o       = 1'b0;
`endif

endmodule
